// File: rtl/ads1672_pkg.sv
// rtl/ads1672_pkg.sv - shared types and constants for the ADS1672 transmit model
//
// Contents:
//   tx_state_e             transmit FSM states (IDLE, CONVERT, DRDY, SHIFT)
//   ADS1672_DATA_WIDTH     default sample width in bits
//   ADS1672_CONV_CYCLES    default conversion time in clk cycles
//   ADS1672_MSB_FIRST      serial bit order of the ADS1672 data port
//   ads1672_cnt_width()    counter width for a modulus, never less than 1
package ads1672_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DRDY    = 2'd2,
        ST_SHIFT   = 2'd3
    } tx_state_e;

    localparam int ADS1672_DATA_WIDTH  = 24;
    localparam int ADS1672_CONV_CYCLES = 16;
    localparam bit ADS1672_MSB_FIRST   = 1'b1;

    function automatic int ads1672_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ads1672_piso.sv
// rtl/ads1672_piso.sv - parallel-load shift register with bit counter
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   load        capture load_data, clear bit counter (wins over shift)
//   shift       advance one bit toward the output, zero fill
//   load_data   WIDTH-bit parallel word
//   msb         current output bit, taken straight from the register
//   last        the bit on msb is the final bit of the word
//
// After WIDTH shifts the register holds all zeros, so msb idles low
// without any extra gating.
module ads1672_piso
    import ads1672_pkg::*;
#(
    parameter int WIDTH = ADS1672_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             msb,
    output logic             last
);

    localparam int CNT_W = ads1672_cnt_width(WIDTH);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = load_data;
            cnt_d = '0;
        end else if (shift) begin
            sr_d  = ADS1672_MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
            cnt_d = (cnt_q == CNT_W'(WIDTH - 1)) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign msb  = ADS1672_MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    assign last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/ads1672_tx_model.sv
// rtl/ads1672_tx_model.sv - ADS1672 data-port emulator: convert, DRDY, serial shift
//
// Ports:
//   clk, rst       system/serial clock, synchronous active-high reset
//   start          conversion request, level-sampled
//   sample_in      next sample, accepted on sample_valid & sample_ready
//   sample_valid   sample_in valid
//   sample_ready   holding register empty (combinational)
//   drr            serial data, MSB first, 0 outside DRDY/SHIFT
//   drdy_n, fsr    data ready, active low; fsr mirrors drdy_n
//   busy           not in IDLE
//   underrun       pulse: conversion ended with no fresh sample
//   start_ignored  pulse: start seen while a frame is on the wire
//
// Build option ADS1672_TX_RAMP_EN: samples come from an internal ramp
// that advances on every frame load; the holding register is removed.
module ads1672_tx_model
    import ads1672_pkg::*;
#(
    parameter int DATA_WIDTH  = ADS1672_DATA_WIDTH,
    parameter int CONV_CYCLES = ADS1672_CONV_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  drr,
    output logic                  drdy_n,
    output logic                  fsr,
    output logic                  busy,
    output logic                  underrun,
    output logic                  start_ignored
);

    localparam int CC_W = ads1672_cnt_width(CONV_CYCLES);

    tx_state_e       state_q, state_d;
    logic [CC_W-1:0] conv_cnt_q, conv_cnt_d;
    logic            drdy_n_q, drdy_n_d;
    logic            busy_q, busy_d;
    logic            underrun_q, underrun_d;
    logic            start_ignored_q, start_ignored_d;

    logic                  conv_done;
    logic                  load;
    logic                  shift;
    logic                  last_bit;
    logic                  underrun_hit;
    logic [DATA_WIDTH-1:0] load_data;

    assign conv_done = (conv_cnt_q == CC_W'(CONV_CYCLES - 1));
    // A restart on the final CONVERT cycle wins over the load.
    assign load      = (state_q == ST_CONVERT) && !start && conv_done;
    assign shift     = (state_q == ST_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            conv_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            conv_cnt_q <= conv_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        conv_cnt_d = conv_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_CONVERT;
                    conv_cnt_d = '0;
                end
            end
            ST_CONVERT: begin
                if (start) begin
                    conv_cnt_d = '0;
                end else if (conv_done) begin
                    state_d = ST_DRDY;
                end else begin
                    conv_cnt_d = conv_cnt_q + 1'b1;
                end
            end
            ST_DRDY:  state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change with it.
    always_comb begin
        drdy_n_d        = (state_d != ST_DRDY);
        busy_d          = (state_d != ST_IDLE);
        underrun_d      = underrun_hit;
        start_ignored_d = start && ((state_q == ST_DRDY) || (state_q == ST_SHIFT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drdy_n_q        <= 1'b1;
            busy_q          <= 1'b0;
            underrun_q      <= 1'b0;
            start_ignored_q <= 1'b0;
        end else begin
            drdy_n_q        <= drdy_n_d;
            busy_q          <= busy_d;
            underrun_q      <= underrun_d;
            start_ignored_q <= start_ignored_d;
        end
    end

`ifdef ADS1672_TX_RAMP_EN
    logic [DATA_WIDTH-1:0] ramp_q, ramp_d;
    logic                  unused_sample;

    assign unused_sample = ^{sample_in, sample_valid};
    assign sample_ready  = 1'b0;
    assign load_data     = ramp_q;
    assign underrun_hit  = 1'b0;

    always_comb begin
        ramp_d = load ? ramp_q + 1'b1 : ramp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp_d;
        end
    end
`else
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] last_q, last_d;
    logic                  hold_valid_q, hold_valid_d;
    logic                  accept;

    assign sample_ready = !hold_valid_q;
    assign accept       = sample_valid && !hold_valid_q;
    // An empty holding register repeats the previous frame's sample.
    assign load_data    = hold_valid_q ? hold_q : last_q;
    assign underrun_hit = load && !hold_valid_q;

    always_comb begin
        hold_d       = accept ? sample_in : hold_q;
        hold_valid_d = hold_valid_q;
        if (load) begin
            hold_valid_d = 1'b0;
        end
        // A sample accepted on the load edge refills the register.
        if (accept) begin
            hold_valid_d = 1'b1;
        end
        last_d = load ? load_data : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            last_q       <= '0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            last_q       <= last_d;
        end
    end
`endif

    ads1672_piso #(
        .WIDTH(DATA_WIDTH)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .load_data(load_data),
        .msb      (drr),
        .last     (last_bit)
    );

    assign drdy_n        = drdy_n_q;
    assign fsr           = drdy_n_q;
    assign busy          = busy_q;
    assign underrun      = underrun_q;
    assign start_ignored = start_ignored_q;

endmodule

// File: tb/tb_ads1672_tx_model.sv
// tb/tb_ads1672_tx_model.sv - self-checking bench for ads1672_tx_model
module tb_ads1672_tx_model;

    localparam int DW       = 24;
    localparam int CC       = 16;
    localparam int WAIT_MAX = 4 * CC + 64;
`ifdef ADS1672_TX_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          drr;
    logic          drdy_n;
    logic          fsr;
    logic          busy;
    logic          underrun;
    logic          start_ignored;

    int vectors = 0;
    int errors  = 0;

    // pulse / anomaly counters, refreshed every cycle by tick
    int n_under, n_ign, n_fsr_bad, n_shift_drdy;

    // observations from the last frame
    logic [DW-1:0] obs_data;
    int            obs_lat;
    logic          obs_first;
    bit            obs_timeout;
    logic          obs_end_busy, obs_end_drr;

    // reference model: one-entry buffer, last sent value, ramp source
    logic [DW-1:0] m_hold, m_last, m_ramp;
    bit            m_hold_valid;

    ads1672_tx_model #(
        .DATA_WIDTH (DW),
        .CONV_CYCLES(CC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .drr          (drr),
        .drdy_n       (drdy_n),
        .fsr          (fsr),
        .busy         (busy),
        .underrun     (underrun),
        .start_ignored(start_ignored)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        if (underrun === 1'b1) n_under++;
        if (start_ignored === 1'b1) n_ign++;
        if (fsr !== drdy_n) n_fsr_bad++;
    endtask

    task automatic clear_counts;
        n_under = 0;
        n_ign = 0;
        n_fsr_bad = 0;
        n_shift_drdy = 0;
    endtask

    task automatic model_reset;
        m_hold = '0;
        m_last = '0;
        m_ramp = '0;
        m_hold_valid = 0;
    endtask

    task automatic model_frame(output logic [DW-1:0] v, output int u);
        u = 0;
        if (RAMP) begin
            v = m_ramp;
            m_ramp = m_ramp + 1;
        end else if (m_hold_valid) begin
            v = m_hold;
            m_hold_valid = 0;
        end else begin
            v = m_last;
            u = 1;
        end
        m_last = v;
    endtask

    task automatic load_sample(input logic [DW-1:0] v);
        sample_in = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        if (!RAMP) begin
            m_hold = v;
            m_hold_valid = 1;
        end
    endtask

    // Runs one frame as a receiver would see it: waits for drdy_n, then
    // collects DW bits, then steps once more into the first IDLE cycle.
    task automatic do_frame(input bit skip_start, input int restart_after, input bit hold_start);
        int n;
        obs_timeout = 0;
        if (!skip_start) begin
            start = 1'b1;
            tick();
        end
        start = 1'b0;
        clear_counts();
        n = 0;
        while (drdy_n === 1'b1 && n < WAIT_MAX) begin
            start = (n == restart_after);
            tick();
            n++;
        end
        start = 1'b0;
        if (n >= WAIT_MAX) begin
            obs_timeout = 1;
            return;
        end
        obs_lat = (restart_after >= 0) ? n - restart_after - 1 : n;
        obs_first = drr;
        if (hold_start) start = 1'b1;
        obs_data = '0;
        for (int i = 0; i < DW; i++) begin
            tick();
            if (drdy_n !== 1'b1) n_shift_drdy++;
            obs_data = {obs_data[DW-2:0], drr};
        end
        tick();
        obs_end_busy = busy;
        obs_end_drr = drr;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        sample_valid = 1'b0;
        tick();
        tick();
        vectors += 7;
        if (drdy_n !== 1'b1) begin errors++; $display("FAIL reset_drdy_n got %b want 1", drdy_n); end
        if (fsr !== 1'b1) begin errors++; $display("FAIL reset_fsr got %b want 1", fsr); end
        if (drr !== 1'b0) begin errors++; $display("FAIL reset_drr got %b want 0", drr); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
        if (start_ignored !== 1'b0) begin errors++; $display("FAIL reset_start_ignored got %b want 0", start_ignored); end
        if (sample_ready !== !RAMP) begin errors++; $display("FAIL reset_sample_ready got %b want %b", sample_ready, !RAMP); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_frame;
        logic [DW-1:0] exp;
        int u;
        load_sample(24'hA5C3F0);
        vectors++;
        if (sample_ready !== 1'b0) begin errors++; $display("FAIL single_ready_after_load got %b want 0", sample_ready); end
        model_frame(exp, u);
        do_frame(0, -1, 0);
        vectors++;
        if (obs_timeout) begin errors++; $display("FAIL single_timeout got no drdy_n want drdy_n low"); return; end
        vectors += 8;
        if (obs_lat !== CC) begin errors++; $display("FAIL single_latency got %0d want %0d", obs_lat, CC); end
        if (obs_first !== exp[DW-1]) begin errors++; $display("FAIL single_drdy_bit got %b want %b", obs_first, exp[DW-1]); end
        if (obs_data !== exp) begin errors++; $display("FAIL single_data got %h want %h", obs_data, exp); end
        if (n_under !== u) begin errors++; $display("FAIL single_underrun got %0d want %0d", n_under, u); end
        if (n_shift_drdy !== 0) begin errors++; $display("FAIL single_drdy_in_shift got %0d want 0", n_shift_drdy); end
        if (n_fsr_bad !== 0) begin errors++; $display("FAIL single_fsr got %0d diffs want 0", n_fsr_bad); end
        if (obs_end_busy !== 1'b0) begin errors++; $display("FAIL single_end_busy got %b want 0", obs_end_busy); end
        if (obs_end_drr !== 1'b0) begin errors++; $display("FAIL single_end_drr got %b want 0", obs_end_drr); end
    endtask

    task automatic test_underrun;
        logic [DW-1:0] exp;
        int u;
        model_frame(exp, u);
        do_frame(0, -1, 0);
        vectors += 3;
        if (obs_timeout) begin errors++; $display("FAIL underrun_timeout got no drdy_n want drdy_n low"); end
        if (obs_data !== exp) begin errors++; $display("FAIL underrun_data got %h want %h", obs_data, exp); end
        if (n_under !== u) begin errors++; $display("FAIL underrun_pulses got %0d want %0d", n_under, u); end
    endtask

    task automatic test_restart;
        logic [DW-1:0] exp;
        int u, extra;
        load_sample(DW'($urandom));
        model_frame(exp, u);
        do_frame(0, 5, 0);
        vectors += 3;
        if (obs_timeout) begin errors++; $display("FAIL restart_timeout got no drdy_n want drdy_n low"); end
        if (obs_lat !== CC) begin errors++; $display("FAIL restart_latency got %0d want %0d", obs_lat, CC); end
        if (obs_data !== exp) begin errors++; $display("FAIL restart_data got %h want %h", obs_data, exp); end
        extra = 0;
        for (int i = 0; i < CC + DW + 8; i++) begin
            tick();
            if (drdy_n !== 1'b1 || busy !== 1'b0) extra++;
        end
        vectors++;
        if (extra !== 0) begin errors++; $display("FAIL restart_second_frame got %0d active cycles want 0", extra); end
    endtask

    task automatic test_start_held;
        logic [DW-1:0] exp;
        int u;
        load_sample(DW'($urandom));
        model_frame(exp, u);
        do_frame(0, -1, 1);
        vectors += 4;
        if (obs_timeout) begin errors++; $display("FAIL held_timeout got no drdy_n want drdy_n low"); end
        if (obs_data !== exp) begin errors++; $display("FAIL held_data got %h want %h", obs_data, exp); end
        if (n_ign !== DW + 1) begin errors++; $display("FAIL held_ignored got %0d want %0d", n_ign, DW + 1); end
        if (obs_end_busy !== 1'b0) begin errors++; $display("FAIL held_idle_busy got %b want 0", obs_end_busy); end
        tick();
        vectors += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL held_restart_busy got %b want 1", busy); end
        if (n_ign !== DW + 1) begin errors++; $display("FAIL held_idle_ignored got %0d want %0d", n_ign, DW + 1); end
        model_frame(exp, u);
        do_frame(1, -1, 0);
        vectors += 3;
        if (obs_lat !== CC) begin errors++; $display("FAIL held_next_latency got %0d want %0d", obs_lat, CC); end
        if (obs_data !== exp) begin errors++; $display("FAIL held_next_data got %h want %h", obs_data, exp); end
        if (n_ign !== 0) begin errors++; $display("FAIL held_next_ignored got %0d want 0", n_ign); end
    endtask

    task automatic test_reset_mid;
        logic [DW-1:0] v, exp;
        int u, n;
        v = DW'($urandom);
        load_sample(v);
        model_frame(exp, u);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (drdy_n === 1'b1 && n < WAIT_MAX) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= WAIT_MAX) begin errors++; $display("FAIL midrst_timeout got no drdy_n want drdy_n low"); return; end
        for (int i = 0; i < DW - 10; i++) tick();
        vectors++;
        if (drr !== exp[10]) begin errors++; $display("FAIL midrst_bit10 got %b want %b", drr, exp[10]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        vectors += 5;
        if (drdy_n !== 1'b1) begin errors++; $display("FAIL midrst_drdy_n got %b want 1", drdy_n); end
        if (fsr !== 1'b1) begin errors++; $display("FAIL midrst_fsr got %b want 1", fsr); end
        if (drr !== 1'b0) begin errors++; $display("FAIL midrst_drr got %b want 0", drr); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        if (sample_ready !== !RAMP) begin errors++; $display("FAIL midrst_ready got %b want %b", sample_ready, !RAMP); end
        model_frame(exp, u);
        do_frame(0, -1, 0);
        vectors += 3;
        if (obs_data !== exp) begin errors++; $display("FAIL midrst_first_data got %h want %h", obs_data, exp); end
        if (n_under !== u) begin errors++; $display("FAIL midrst_first_underrun got %0d want %0d", n_under, u); end
        if (obs_lat !== CC) begin errors++; $display("FAIL midrst_latency got %0d want %0d", obs_lat, CC); end
        load_sample(DW'($urandom));
        model_frame(exp, u);
        do_frame(0, -1, 0);
        vectors++;
        if (obs_data !== exp) begin errors++; $display("FAIL midrst_next_data got %h want %h", obs_data, exp); end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] exp;
        int u;
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 2) != 0) load_sample(DW'($urandom));
            model_frame(exp, u);
            do_frame(0, -1, 0);
            vectors += 3;
            if (obs_data !== exp) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", k, obs_data, exp); end
            if (obs_lat !== CC) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want %0d", k, obs_lat, CC); end
            if (n_under !== u) begin errors++; $display("FAIL b2b_underrun[%0d] got %0d want %0d", k, n_under, u); end
        end
    endtask

`ifdef ADS1672_TX_RAMP_EN
    task automatic test_ramp;
        for (int k = 0; k < 3; k++) begin
            do_frame(0, -1, 0);
            m_ramp = m_ramp + 1;
            m_last = DW'(k);
            vectors += 3;
            if (obs_data !== DW'(k)) begin errors++; $display("FAIL ramp_data[%0d] got %h want %h", k, obs_data, DW'(k)); end
            if (sample_ready !== 1'b0) begin errors++; $display("FAIL ramp_ready[%0d] got %b want 0", k, sample_ready); end
            if (n_under !== 0) begin errors++; $display("FAIL ramp_underrun[%0d] got %0d want 0", k, n_under); end
        end
    endtask
`endif

    initial begin
        clear_counts();
        model_reset();
        test_reset();
`ifdef ADS1672_TX_RAMP_EN
        test_ramp();
`endif
        test_single_frame();
        test_underrun();
        test_restart();
        test_start_held();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
